// File: rtl/wt_store_wbuf_if.sv
// Handshake and payload bundle between the store unit, the store buffer and the cache memory port.
interface wt_store_wbuf_if #(
    parameter int DEPTH  = 8,
    parameter int ADDR_W = 64,
    parameter int DATA_W = 64
);
    localparam int BE_W  = DATA_W / 8;
    localparam int TID_W = $clog2(DEPTH);

    logic              req_valid_i;
    logic              req_ready_o;
    logic [ADDR_W-1:0] req_addr_i;
    logic [DATA_W-1:0] req_data_i;
    logic [BE_W-1:0]   req_be_i;

    logic              mem_valid_o;
    logic              mem_ready_i;
    logic [ADDR_W-1:0] mem_addr_o;
    logic [DATA_W-1:0] mem_data_o;
    logic [BE_W-1:0]   mem_be_o;
    logic [TID_W-1:0]  mem_tid_o;

    logic              ack_valid_i;
    logic [TID_W-1:0]  ack_tid_i;

    logic [ADDR_W-1:0] rd_addr_i;
    logic              rd_hit_o;
    logic              flush_i;
    logic              empty_o;

    modport slave (
        input  req_valid_i, req_addr_i, req_data_i, req_be_i,
        output req_ready_o,
        output mem_valid_o, mem_addr_o, mem_data_o, mem_be_o, mem_tid_o,
        input  mem_ready_i,
        input  ack_valid_i, ack_tid_i,
        input  rd_addr_i, flush_i,
        output rd_hit_o, empty_o
    );

    modport master (
        output req_valid_i, req_addr_i, req_data_i, req_be_i,
        input  req_ready_o,
        input  mem_valid_o, mem_addr_o, mem_data_o, mem_be_o, mem_tid_o,
        output mem_ready_i,
        output ack_valid_i, ack_tid_i,
        output rd_addr_i, flush_i,
        input  rd_hit_o, empty_o
    );
endinterface

// File: rtl/wt_store_wbuf.sv
// Write-through store buffer: in-order allocation and issue, out-of-order acks, in-order retirement.
// Byte-enable merging into pending same-word entries is compiled in only with WT_WBUF_MERGE_EN.
module wt_store_wbuf #(
    parameter int DEPTH   = 8,
    parameter int ADDR_W  = 64,
    parameter int DATA_W  = 64,
    parameter int MAX_OUT = 4
) (
    input  logic           clk_i,
    input  logic           rst_i,
    wt_store_wbuf_if.slave bus
);
    localparam int BE_W    = DATA_W / 8;
    localparam int TID_W   = $clog2(DEPTH);
    localparam int PTR_W   = TID_W + 1;
    localparam int WADDR_W = ADDR_W - 3;

    localparam logic [PTR_W-1:0] PTR_INC = {{(PTR_W-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        ST_FREE   = 2'd0,
        ST_PEND   = 2'd1,
        ST_ISSUED = 2'd2,
        ST_ACKED  = 2'd3
    } entry_state_e;

    entry_state_e       state_r [DEPTH];
    logic [WADDR_W-1:0] addr_r  [DEPTH];
    logic [DATA_W-1:0]  data_r  [DEPTH];
    logic [BE_W-1:0]    be_r    [DEPTH];
    logic [PTR_W-1:0]   head_r;
    logic [PTR_W-1:0]   iss_r;
    logic [PTR_W-1:0]   tail_r;

    logic [PTR_W-1:0]   count_s;
    logic [PTR_W-1:0]   out_s;
    logic [TID_W-1:0]   head_idx_s;
    logic [TID_W-1:0]   iss_idx_s;
    logic [TID_W-1:0]   tail_idx_s;
    logic [WADDR_W-1:0] req_waddr_s;
    logic [WADDR_W-1:0] rd_waddr_s;
    logic               full_s;
    logic               ready_s;
    logic               mem_valid_s;
    logic               accept_s;
    logic               issue_s;
    logic               ack_hit_s;
    logic               retire_s;
    logic               alloc_s;
    logic               rd_hit_s;
    logic [ADDR_W-1:0]  mem_addr_s;
    logic [DATA_W-1:0]  mem_data_s;
    logic [BE_W-1:0]    mem_be_s;
    logic [TID_W-1:0]   mem_tid_s;
    logic               unused_addr_lsb_s;

    // The wrap bit makes tail-head equal DEPTH when full and zero when empty.
    assign count_s     = tail_r - head_r;
    assign out_s       = iss_r - head_r;
    assign head_idx_s  = head_r[TID_W-1:0];
    assign iss_idx_s   = iss_r[TID_W-1:0];
    assign tail_idx_s  = tail_r[TID_W-1:0];
    assign req_waddr_s = bus.req_addr_i[ADDR_W-1:3];
    assign rd_waddr_s  = bus.rd_addr_i[ADDR_W-1:3];
    assign unused_addr_lsb_s = ^{bus.req_addr_i[2:0], bus.rd_addr_i[2:0]};

    assign full_s      = (count_s == PTR_W'(DEPTH));
    assign ready_s     = !full_s && !bus.flush_i;
    assign mem_valid_s = (iss_r != tail_r) && (out_s < PTR_W'(MAX_OUT));
    assign accept_s    = bus.req_valid_i && ready_s;
    assign issue_s     = mem_valid_s && bus.mem_ready_i;
    assign ack_hit_s   = bus.ack_valid_i && (state_r[bus.ack_tid_i] == ST_ISSUED);
    assign retire_s    = (state_r[head_idx_s] == ST_ACKED);

`ifdef WT_WBUF_MERGE_EN
    logic [DEPTH-1:0]  merge_vec_s;
    logic [TID_W-1:0]  merge_idx_s;
    logic              merge_s;
    logic [DATA_W-1:0] merge_data_s;

    // Merge candidate search: pending same-word entry that is not the one presented to memory.
    always_comb begin
        merge_vec_s = {DEPTH{1'b0}};
        merge_idx_s = {TID_W{1'b0}};
        for (int i = 0; i < DEPTH; i++) begin
            merge_vec_s[i] = (state_r[i] == ST_PEND) && (addr_r[i] == req_waddr_s) &&
                             !(mem_valid_s && (iss_idx_s == TID_W'(i)));
            merge_idx_s = merge_idx_s | (merge_vec_s[i] ? TID_W'(i) : {TID_W{1'b0}});
        end
    end

    assign merge_s = accept_s && (|merge_vec_s);
    assign alloc_s = accept_s && !(|merge_vec_s);

    // Byte-lane overlay of the incoming store onto the candidate's data.
    always_comb begin
        merge_data_s = data_r[merge_idx_s];
        for (int b = 0; b < BE_W; b++) begin
            if (bus.req_be_i[b]) begin
                merge_data_s[b*8 +: 8] = bus.req_data_i[b*8 +: 8];
            end else begin
                merge_data_s[b*8 +: 8] = data_r[merge_idx_s][b*8 +: 8];
            end
        end
    end
`else
    assign alloc_s = accept_s;
`endif

    // Load hazard detection against every live entry.
    always_comb begin
        rd_hit_s = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            rd_hit_s = rd_hit_s | ((state_r[i] != ST_FREE) && (addr_r[i] == rd_waddr_s));
        end
    end

    // Memory payload taken from the issue entry, zeroed while nothing is presented.
    always_comb begin
        if (mem_valid_s) begin
            mem_addr_s = {addr_r[iss_idx_s], 3'b000};
            mem_data_s = data_r[iss_idx_s];
            mem_be_s   = be_r[iss_idx_s];
            mem_tid_s  = iss_idx_s;
        end else begin
            mem_addr_s = {ADDR_W{1'b0}};
            mem_data_s = {DATA_W{1'b0}};
            mem_be_s   = {BE_W{1'b0}};
            mem_tid_s  = {TID_W{1'b0}};
        end
    end

    // Entry lifecycle and pointers; each transition requires a distinct current state,
    // so allocate, issue, ack and retire never target the same entry in one cycle.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            head_r <= {PTR_W{1'b0}};
            iss_r  <= {PTR_W{1'b0}};
            tail_r <= {PTR_W{1'b0}};
            for (int i = 0; i < DEPTH; i++) begin
                state_r[i] <= ST_FREE;
                addr_r[i]  <= {WADDR_W{1'b0}};
                data_r[i]  <= {DATA_W{1'b0}};
                be_r[i]    <= {BE_W{1'b0}};
            end
        end else begin
            if (alloc_s) begin
                state_r[tail_idx_s] <= ST_PEND;
                addr_r[tail_idx_s]  <= req_waddr_s;
                data_r[tail_idx_s]  <= bus.req_data_i;
                be_r[tail_idx_s]    <= bus.req_be_i;
                tail_r              <= tail_r + PTR_INC;
            end
`ifdef WT_WBUF_MERGE_EN
            if (merge_s) begin
                data_r[merge_idx_s] <= merge_data_s;
                be_r[merge_idx_s]   <= be_r[merge_idx_s] | bus.req_be_i;
            end
`endif
            if (issue_s) begin
                state_r[iss_idx_s] <= ST_ISSUED;
                iss_r              <= iss_r + PTR_INC;
            end
            if (ack_hit_s) begin
                state_r[bus.ack_tid_i] <= ST_ACKED;
            end
            if (retire_s) begin
                state_r[head_idx_s] <= ST_FREE;
                head_r              <= head_r + PTR_INC;
            end
        end
    end

    assign bus.req_ready_o = ready_s;
    assign bus.mem_valid_o = mem_valid_s;
    assign bus.mem_addr_o  = mem_addr_s;
    assign bus.mem_data_o  = mem_data_s;
    assign bus.mem_be_o    = mem_be_s;
    assign bus.mem_tid_o   = mem_tid_s;
    assign bus.rd_hit_o    = rd_hit_s;
    assign bus.empty_o     = (head_r == tail_r);

endmodule

// File: tb/tb_wt_store_wbuf.sv
// Bench for wt_store_wbuf: directed scenarios plus random traffic against a queue-based store model.
module tb_wt_store_wbuf;
    localparam int DEPTH   = 8;
    localparam int ADDR_W  = 64;
    localparam int DATA_W  = 64;
    localparam int MAX_OUT = 4;
    localparam int TID_W   = $clog2(DEPTH);

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    wt_store_wbuf_if #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

    wt_store_wbuf #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .MAX_OUT(MAX_OUT)) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );

    // Model: live stores in allocation order; st 0=waiting, 1=sent to memory, 2=acknowledged.
    typedef struct {
        logic [60:0] waddr;
        logic [63:0] data;
        logic [7:0]  be;
        int          slot;
        int          st;
    } ment_t;

    ment_t mq[$];
    int    nalloc = 0;
    int    vectors = 0;
    int    miscompares = 0;

    function automatic int m_iss();
        for (int i = 0; i < mq.size(); i++) if (mq[i].st == 0) return i;
        return -1;
    endfunction

    function automatic int m_out();
        int n = 0;
        foreach (mq[i]) if (mq[i].st != 0) n++;
        return n;
    endfunction

    function automatic bit m_mem_valid();
        return (m_iss() >= 0) && (m_out() < MAX_OUT);
    endfunction

    function automatic bit m_ready();
        return (mq.size() < DEPTH) && !bus.flush_i;
    endfunction

    function automatic bit m_rd_hit();
        foreach (mq[i]) if (mq[i].waddr == bus.rd_addr_i[63:3]) return 1'b1;
        return 1'b0;
    endfunction

    task automatic idle();
        bus.req_valid_i = 1'b0;
        bus.req_addr_i  = 64'h0;
        bus.req_data_i  = 64'h0;
        bus.req_be_i    = 8'h00;
        bus.mem_ready_i = 1'b0;
        bus.ack_valid_i = 1'b0;
        bus.ack_tid_i   = '0;
        bus.rd_addr_i   = 64'h0;
        bus.flush_i     = 1'b0;
    endtask

    // One clock: the model takes the same inputs the DUT samples at this edge.
    task automatic tick();
        bit    retire, mv, acc;
        int    j, m;
        ment_t e;
        retire = (mq.size() > 0) && (mq[0].st == 2);
        mv     = m_mem_valid();
        j      = m_iss();
        acc    = bus.req_valid_i && m_ready();
        @(posedge clk);
        if (rst) begin
            mq.delete();
            nalloc = 0;
        end else begin
            if (bus.ack_valid_i)
                foreach (mq[i]) if (mq[i].slot == int'(bus.ack_tid_i) && mq[i].st == 1) mq[i].st = 2;
            if (mv && bus.mem_ready_i) mq[j].st = 1;
            if (acc) begin
                m = -1;
`ifdef WT_WBUF_MERGE_EN
                foreach (mq[i])
                    if (mq[i].st == 0 && mq[i].waddr == bus.req_addr_i[63:3] && !(mv && i == j)) m = i;
`endif
                if (m >= 0) begin
                    for (int b = 0; b < 8; b++)
                        if (bus.req_be_i[b]) mq[m].data[b*8 +: 8] = bus.req_data_i[b*8 +: 8];
                    mq[m].be = mq[m].be | bus.req_be_i;
                end else begin
                    e.waddr = bus.req_addr_i[63:3];
                    e.data  = bus.req_data_i;
                    e.be    = bus.req_be_i;
                    e.slot  = nalloc % DEPTH;
                    e.st    = 0;
                    mq.push_back(e);
                    nalloc++;
                end
            end
            if (retire) void'(mq.pop_front());
        end
        #1;
    endtask

    task automatic put(input logic [63:0] a, input logic [63:0] d, input logic [7:0] be);
        bus.req_valid_i = 1'b1;
        bus.req_addr_i  = a;
        bus.req_data_i  = d;
        bus.req_be_i    = be;
        tick();
        bus.req_valid_i = 1'b0;
    endtask

    task automatic ack(input int tid);
        bus.ack_valid_i = 1'b1;
        bus.ack_tid_i   = TID_W'(tid);
        tick();
        bus.ack_valid_i = 1'b0;
    endtask

    task automatic issue_n(input int n);
        bus.mem_ready_i = 1'b1;
        for (int k = 0; k < n; k++) tick();
        bus.mem_ready_i = 1'b0;
    endtask

    // Let memory accept and acknowledge until both model and DUT are empty (bounded).
    task automatic drain();
        int issued[$];
        for (int c = 0; c < 400; c++) begin
            if (mq.size() == 0 && bus.empty_o === 1'b1) break;
            bus.req_valid_i = 1'b0;
            bus.mem_ready_i = ($urandom_range(0, 3) != 0);
            issued.delete();
            foreach (mq[i]) if (mq[i].st == 1) issued.push_back(mq[i].slot);
            if (issued.size() > 0 && $urandom_range(0, 1) == 1) begin
                bus.ack_valid_i = 1'b1;
                bus.ack_tid_i   = TID_W'(issued[$urandom_range(0, issued.size() - 1)]);
            end else begin
                bus.ack_valid_i = 1'b0;
            end
            tick();
        end
        bus.ack_valid_i = 1'b0;
        bus.mem_ready_i = 1'b0;
    endtask

    task automatic test_reset();
        idle();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        #1;
        vectors++; if (bus.req_ready_o !== 1'b1) begin miscompares++; $display("FAIL reset_ready: got %b want 1", bus.req_ready_o); end
        vectors++; if (bus.mem_valid_o !== 1'b0) begin miscompares++; $display("FAIL reset_mem_valid: got %b want 0", bus.mem_valid_o); end
        vectors++; if (bus.empty_o !== 1'b1) begin miscompares++; $display("FAIL reset_empty: got %b want 1", bus.empty_o); end
        vectors++; if (bus.rd_hit_o !== 1'b0) begin miscompares++; $display("FAIL reset_rd_hit: got %b want 0", bus.rd_hit_o); end
        vectors++; if (bus.mem_addr_o !== 64'h0 || bus.mem_tid_o !== '0) begin miscompares++; $display("FAIL reset_payload: got addr %h tid %0d want 0", bus.mem_addr_o, bus.mem_tid_o); end
    endtask

    task automatic test_fill_drain();
        int tids[$];
        idle();
        for (int i = 0; i < 8; i++) put(64'h100 + 64'(i * 8), {$urandom, $urandom}, 8'hFF);
        #1;
        vectors++; if (bus.req_ready_o !== 1'b0) begin miscompares++; $display("FAIL fill_full_ready: got %b want 0", bus.req_ready_o); end
        bus.mem_ready_i = 1'b1;
        for (int c = 0; c < 6; c++) begin
            #1;
            vectors++; if (bus.mem_valid_o !== m_mem_valid()) begin miscompares++; $display("FAIL fill_issue_valid: cycle %0d got %b want %b", c, bus.mem_valid_o, m_mem_valid()); end
            if (bus.mem_valid_o === 1'b1) tids.push_back(int'(bus.mem_tid_o));
            tick();
        end
        bus.mem_ready_i = 1'b0;
        vectors++;
        if (tids.size() != 4 || tids[0] != 0 || tids[1] != 1 || tids[2] != 2 || tids[3] != 3) begin
            miscompares++; $display("FAIL fill_issue_tids: got %p want 0,1,2,3", tids);
        end
        ack(2);
        ack(1);
        tick();
        tick();
        vectors++; if (bus.req_ready_o !== 1'b0) begin miscompares++; $display("FAIL fill_head_holds: ready %b want 0", bus.req_ready_o); end
        ack(0);
        vectors++; if (bus.req_ready_o !== 1'b0) begin miscompares++; $display("FAIL fill_ack_no_free_yet: ready %b want 0", bus.req_ready_o); end
        tick();
        vectors++; if (bus.req_ready_o !== 1'b1) begin miscompares++; $display("FAIL fill_freed0_ready: got %b want 1", bus.req_ready_o); end
        vectors++; if (bus.mem_valid_o !== 1'b1 || bus.mem_tid_o !== 3'd4) begin miscompares++; $display("FAIL fill_next_issue: valid %b tid %0d want 1 tid 4", bus.mem_valid_o, bus.mem_tid_o); end
        tick();
        tick();
        vectors++; if (bus.mem_valid_o !== m_mem_valid()) begin miscompares++; $display("FAIL fill_after_retire: valid %b want %b", bus.mem_valid_o, m_mem_valid()); end
        drain();
        vectors++; if (bus.empty_o !== 1'b1) begin miscompares++; $display("FAIL fill_drained_empty: got %b want 1", bus.empty_o); end
    endtask

    task automatic test_merge();
        int s0, s1;
        logic [7:0]  be_first;
        logic [63:0] data_first;
        idle();
        for (int i = 0; i < 4; i++) put(64'h500 + 64'(i * 8), {$urandom, $urandom}, 8'hFF);
        issue_n(4);
        put(64'h1000, 64'h00000000_11223344, 8'h0F);
        put(64'h1004, 64'h55667788_00000000, 8'hF0);
        #1;
        vectors++; if (bus.mem_valid_o !== 1'b0) begin miscompares++; $display("FAIL merge_stalled: valid %b want 0", bus.mem_valid_o); end
        s0 = mq[0].slot;
        s1 = mq[1].slot;
        ack(s0);
        ack(s1);
        tick();
`ifdef WT_WBUF_MERGE_EN
        be_first = 8'hFF; data_first = 64'h55667788_11223344;
`else
        be_first = 8'h0F; data_first = 64'h00000000_11223344;
`endif
        vectors++;
        if (bus.mem_valid_o !== 1'b1 || bus.mem_addr_o !== 64'h1000 || bus.mem_be_o !== be_first || bus.mem_data_o !== data_first) begin
            miscompares++; $display("FAIL merge_payload: v %b a %h be %h d %h want 1 1000 %h %h", bus.mem_valid_o, bus.mem_addr_o, bus.mem_be_o, bus.mem_data_o, be_first, data_first);
        end
        issue_n(1);
`ifdef WT_WBUF_MERGE_EN
        vectors++; if (bus.mem_valid_o !== 1'b0) begin miscompares++; $display("FAIL merge_single_entry: valid %b want 0", bus.mem_valid_o); end
`else
        vectors++;
        if (bus.mem_valid_o !== 1'b1 || bus.mem_be_o !== 8'hF0 || bus.mem_data_o !== 64'h55667788_00000000) begin
            miscompares++; $display("FAIL merge_second_entry: v %b be %h d %h want 1 f0 5566778800000000", bus.mem_valid_o, bus.mem_be_o, bus.mem_data_o);
        end
`endif
        drain();
    endtask

    task automatic test_no_merge_presented();
        idle();
        put(64'h2000, 64'hAAAA_0000_AAAA_0001, 8'hFF);
        put(64'h2000, 64'hBBBB_0000_BBBB_0002, 8'hFF);
        #1;
        vectors++; if (bus.mem_valid_o !== 1'b1 || bus.mem_data_o !== 64'hAAAA_0000_AAAA_0001) begin miscompares++; $display("FAIL presented_stable: v %b d %h want 1 aaaa0000aaaa0001", bus.mem_valid_o, bus.mem_data_o); end
        issue_n(1);
        vectors++;
        if (bus.mem_valid_o !== 1'b1 || bus.mem_addr_o !== 64'h2000 || bus.mem_data_o !== 64'hBBBB_0000_BBBB_0002) begin
            miscompares++; $display("FAIL presented_new_entry: v %b a %h d %h want 1 2000 bbbb0000bbbb0002", bus.mem_valid_o, bus.mem_addr_o, bus.mem_data_o);
        end
        drain();
    endtask

    task automatic test_wrap_random();
        int issued[$];
        int j;
        idle();
        for (int c = 0; c < 400; c++) begin
            bus.req_valid_i = $urandom_range(0, 1) == 1;
            bus.req_addr_i  = 64'h4000 + 64'($urandom_range(0, 5) * 8) + 64'($urandom_range(0, 7));
            bus.req_data_i  = {$urandom, $urandom};
            bus.req_be_i    = 8'($urandom);
            bus.mem_ready_i = $urandom_range(0, 1) == 1;
            bus.rd_addr_i   = 64'h4000 + 64'($urandom_range(0, 7) * 8) + 64'($urandom_range(0, 7));
            issued.delete();
            foreach (mq[i]) if (mq[i].st == 1) issued.push_back(mq[i].slot);
            bus.ack_valid_i = $urandom_range(0, 2) == 0;
            if (issued.size() > 0 && $urandom_range(0, 3) != 0) bus.ack_tid_i = TID_W'(issued[$urandom_range(0, issued.size() - 1)]);
            else bus.ack_tid_i = TID_W'($urandom_range(0, DEPTH - 1));
            #1;
            j = m_iss();
            vectors++; if (bus.req_ready_o !== m_ready()) begin miscompares++; $display("FAIL rnd_ready: cycle %0d got %b want %b", c, bus.req_ready_o, m_ready()); end
            vectors++; if (bus.mem_valid_o !== m_mem_valid()) begin miscompares++; $display("FAIL rnd_mem_valid: cycle %0d got %b want %b", c, bus.mem_valid_o, m_mem_valid()); end
            if (m_mem_valid()) begin
                vectors++;
                if (bus.mem_addr_o !== {mq[j].waddr, 3'b000} || bus.mem_data_o !== mq[j].data || bus.mem_be_o !== mq[j].be || int'(bus.mem_tid_o) != mq[j].slot) begin
                    miscompares++; $display("FAIL rnd_payload: cycle %0d got a %h d %h be %h tid %0d want a %h d %h be %h tid %0d", c, bus.mem_addr_o, bus.mem_data_o, bus.mem_be_o, bus.mem_tid_o, {mq[j].waddr, 3'b000}, mq[j].data, mq[j].be, mq[j].slot);
                end
            end
            vectors++; if (bus.rd_hit_o !== m_rd_hit()) begin miscompares++; $display("FAIL rnd_rd_hit: cycle %0d got %b want %b", c, bus.rd_hit_o, m_rd_hit()); end
            vectors++; if (bus.empty_o !== (mq.size() == 0)) begin miscompares++; $display("FAIL rnd_empty: cycle %0d got %b want %b", c, bus.empty_o, mq.size() == 0); end
            tick();
        end
        idle();
        drain();
        vectors++; if (bus.empty_o !== 1'b1) begin miscompares++; $display("FAIL rnd_final_empty: got %b want 1", bus.empty_o); end
    endtask

    task automatic test_full_ack_accept();
        idle();
        for (int i = 0; i < 8; i++) put(64'h600 + 64'(i * 8), {$urandom, $urandom}, 8'hFF);
        issue_n(4);
        bus.ack_valid_i = 1'b1;
        bus.ack_tid_i   = TID_W'(mq[0].slot);
        bus.req_valid_i = 1'b1;
        bus.req_addr_i  = 64'h700;
        bus.req_data_i  = 64'h7;
        bus.req_be_i    = 8'hFF;
        #1;
        vectors++; if (bus.req_ready_o !== 1'b0) begin miscompares++; $display("FAIL full_ack_same_cycle: ready %b want 0", bus.req_ready_o); end
        tick();
        bus.ack_valid_i = 1'b0;
        #1;
        vectors++; if (bus.req_ready_o !== 1'b0) begin miscompares++; $display("FAIL full_retire_cycle: ready %b want 0", bus.req_ready_o); end
        tick();
        vectors++; if (bus.req_ready_o !== 1'b1) begin miscompares++; $display("FAIL full_after_free: ready %b want 1", bus.req_ready_o); end
        tick();
        bus.req_valid_i = 1'b0;
        #1;
        vectors++; if (bus.req_ready_o !== 1'b0) begin miscompares++; $display("FAIL full_refill: ready %b want 0", bus.req_ready_o); end
        drain();
    endtask

    task automatic test_hazard_flush();
        idle();
        bus.rd_addr_i = 64'h3008;
        #1;
        vectors++; if (bus.rd_hit_o !== 1'b0) begin miscompares++; $display("FAIL hazard_none: got %b want 0", bus.rd_hit_o); end
        put(64'h3008, 64'h1234, 8'h03);
        vectors++; if (bus.rd_hit_o !== 1'b1) begin miscompares++; $display("FAIL hazard_pend: got %b want 1", bus.rd_hit_o); end
        issue_n(1);
        ack(mq[0].slot);
        vectors++; if (bus.rd_hit_o !== 1'b1) begin miscompares++; $display("FAIL hazard_acked: got %b want 1", bus.rd_hit_o); end
        tick();
        vectors++; if (bus.rd_hit_o !== 1'b0) begin miscompares++; $display("FAIL hazard_retired: got %b want 0", bus.rd_hit_o); end
        put(64'h3100, 64'h1, 8'hFF);
        put(64'h3108, 64'h2, 8'hFF);
        bus.flush_i     = 1'b1;
        bus.req_valid_i = 1'b1;
        bus.req_addr_i  = 64'h3200;
        #1;
        vectors++; if (bus.req_ready_o !== 1'b0) begin miscompares++; $display("FAIL flush_ready: got %b want 0", bus.req_ready_o); end
        tick();
        bus.req_valid_i = 1'b0;
        vectors++; if (bus.empty_o !== 1'b0) begin miscompares++; $display("FAIL flush_not_empty: got %b want 0", bus.empty_o); end
        drain();
        vectors++; if (bus.empty_o !== 1'b1 || bus.req_ready_o !== 1'b0) begin miscompares++; $display("FAIL flush_drained: empty %b ready %b want 1 0", bus.empty_o, bus.req_ready_o); end
        bus.flush_i = 1'b0;
    endtask

    task automatic test_reset_midflight();
        idle();
        put(64'h7000, 64'h70, 8'hFF);
        put(64'h7008, 64'h71, 8'hFF);
        put(64'h7010, 64'h72, 8'hFF);
        issue_n(3);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        vectors++; if (bus.empty_o !== 1'b1 || bus.mem_valid_o !== 1'b0) begin miscompares++; $display("FAIL midreset_state: empty %b valid %b want 1 0", bus.empty_o, bus.mem_valid_o); end
        for (int t = 0; t < 3; t++) ack(t);
        tick();
        vectors++; if (bus.empty_o !== 1'b1) begin miscompares++; $display("FAIL midreset_late_ack: empty %b want 1", bus.empty_o); end
        put(64'h7100, 64'h99, 8'hFF);
        vectors++;
        if (bus.mem_valid_o !== 1'b1 || bus.mem_tid_o !== 3'd0 || bus.mem_addr_o !== 64'h7100) begin
            miscompares++; $display("FAIL midreset_new_store: v %b tid %0d a %h want 1 0 7100", bus.mem_valid_o, bus.mem_tid_o, bus.mem_addr_o);
        end
        drain();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        idle();
        test_reset();
        test_fill_drain();
        test_merge();
        test_no_merge_presented();
        test_wrap_random();
        test_full_ack_accept();
        test_hazard_flush();
        test_reset_midflight();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
